// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package rf_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int PRESET_ADDR_DEF = 2;
  localparam logic [31:0] PRESET_VAL_DEF = 32'h0000_0123;

  // CLEAR sweeps storage after reset, RUN is normal operation.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read mux: hardwired-zero entry, optional write bypass
// (port 1 has priority over port 0), and forced-zero output while sweeping.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic              w0_i,
  input  logic [ADDR_W-1:0] wr0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              w1_i,
  input  logic [ADDR_W-1:0] wr1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic [DATA_W-1:0] data_o
);

  logic is_zero_s;
  logic hit0_s;
  logic hit1_s;

  // Select the read value: zero register first, then bypass, then storage.
  always_comb begin
    data_o    = '0;
    is_zero_s = (ZERO_REG != 0) && (addr_i == '0);
    hit1_s    = (BYPASS != 0) && w1_i && (wr1_i == addr_i);
    hit0_s    = (BYPASS != 0) && w0_i && (wr0_i == addr_i);
    if (!run_i || is_zero_s) begin
      data_o = '0;
    end else if (hit1_s) begin
      data_o = wd1_i;
    end else if (hit0_s) begin
      data_o = wd0_i;
    end else begin
      data_o = entry_i;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NUM_RD combinational read ports, two write
// ports with port-1-wins arbitration, a debug read port and a post-reset
// clear sweep that also loads one preset entry.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int PRESET_ADDR = PRESET_ADDR_DEF,
  parameter logic [DATA_W-1:0] PRESET_VAL = DATA_W'(PRESET_VAL_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rr,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     w0,
  input  logic                     w1,
  input  logic [ADDR_W-1:0]        wr0,
  input  logic [ADDR_W-1:0]        wr1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PRESET_A    = ADDR_W'(PRESET_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run_s;
  logic we0_s;
  logic we1_s;

  assign run_s = (state_q == ST_RUN);
  assign busy  = (state_q == ST_CLEAR);

  // Write arbitration: zero entry is read-only, and on an address clash port 0 yields.
  always_comb begin
    we0_s = 1'b0;
    we1_s = 1'b0;
    if (run_s) begin
      we1_s = w1 && !((ZERO_REG != 0) && (wr1 == '0));
      we0_s = w0 && !((ZERO_REG != 0) && (wr0 == '0)) && !(w1 && (wr1 == wr0));
    end else begin
      we0_s = 1'b0;
      we1_s = 1'b0;
    end
  end

  // Sweep FSM: compare-before-increment so the pointer never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST_ADDR) begin
            state_q <= ST_RUN;
          end else begin
            ptr_q <= ptr_q + ONE_A;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Storage: sweep writes while clearing, arbitrated write ports while running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[ptr_q] <= (ptr_q == PRESET_A) ? PRESET_VAL : '0;
      end else begin
        if (we0_s) begin
          mem_q[wr0] <= wd0;
        end
        if (we1_s) begin
          mem_q[wr1] <= wd1;
        end
      end
    end
  end

  // Debug port reads storage directly, never the bypass path.
  assign dbg_data = run_s ? mem_q[dbg_addr] : '0;

  logic [ADDR_W-1:0] rp_addr_s [NUM_RD];
  logic [DATA_W-1:0] rp_data_s [NUM_RD];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rp_addr_s[k] = rr[k*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rp (
      .run_i  (run_s),
      .addr_i (rp_addr_s[k]),
      .entry_i(mem_q[rp_addr_s[k]]),
      .w0_i   (w0),
      .wr0_i  (wr0),
      .wd0_i  (wd0),
      .w1_i   (w1),
      .wr1_i  (wr1),
      .wd1_i  (wd1),
      .data_o (rp_data_s[k])
    );

    assign rd[k*DATA_W +: DATA_W] = rp_data_s[k];
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench: bypass and non-bypass 32x32 files share stimulus,
// a third 8x16 three-port file runs alongside; all checked against array models.
module tb_rf_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  rr_ab;
  logic [63:0] rd_a, rd_b;
  logic        w0, w1;
  logic [4:0]  wr0, wr1, dbg_ab;
  logic [31:0] wd0, wd1, dbg_a, dbg_b;
  logic        busy_a, busy_b;

  logic [8:0]  rr_c;
  logic [47:0] rd_c;
  logic        w0_c, w1_c;
  logic [2:0]  wr0_c, wr1_c, dbg_c_addr;
  logic [15:0] wd0_c, wd1_c, dbg_c;
  logic        busy_c;

  int total = 0;
  int bad = 0;

  logic [31:0] ref_ab [32];
  logic [15:0] ref_c [8];

  rf_multiport u_a (
    .clk(clk), .rst(rst), .rr(rr_ab), .rd(rd_a), .w0(w0), .w1(w1), .wr0(wr0), .wr1(wr1),
    .wd0(wd0), .wd1(wd1), .dbg_addr(dbg_ab), .dbg_data(dbg_a), .busy(busy_a));

  rf_multiport #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rr(rr_ab), .rd(rd_b), .w0(w0), .w1(w1), .wr0(wr0), .wr1(wr1),
    .wd0(wd0), .wd1(wd1), .dbg_addr(dbg_ab), .dbg_data(dbg_b), .busy(busy_b));

  rf_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) u_c (
    .clk(clk), .rst(rst), .rr(rr_c), .rd(rd_c), .w0(w0_c), .w1(w1_c), .wr0(wr0_c), .wr1(wr1_c),
    .wd0(wd0_c), .wd1(wd1_c), .dbg_addr(dbg_c_addr), .dbg_data(dbg_c), .busy(busy_c));

  // Expected read of the 32-bit files given the currently driven write inputs.
  function automatic logic [31:0] exp_ab(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && w1 && wr1 == a) return wd1;
    if (byp && w0 && wr0 == a) return wd0;
    return ref_ab[a];
  endfunction

  function automatic logic [15:0] exp_c(input logic [2:0] a);
    if (a == 3'd0) return 16'd0;
    if (w1_c && wr1_c == a) return wd1_c;
    if (w0_c && wr0_c == a) return wd0_c;
    return ref_c[a];
  endfunction

  // Apply port 0 then port 1, so port 1 naturally wins a clash.
  task automatic commit_models();
    if (w0 && wr0 != 5'd0) ref_ab[wr0] = wd0;
    if (w1 && wr1 != 5'd0) ref_ab[wr1] = wd1;
    if (w0_c && wr0_c != 3'd0) ref_c[wr0_c] = wd0_c;
    if (w1_c && wr1_c != 3'd0) ref_c[wr1_c] = wd1_c;
  endtask

  task automatic init_models();
    for (int i = 0; i < 32; i++) ref_ab[i] = 32'd0;
    for (int i = 0; i < 8; i++) ref_c[i] = 16'd0;
    ref_ab[2] = 32'h0000_0123;
    ref_c[2]  = 16'h0123;
  endtask

  task automatic idle();
    w0 = 1'b0; w1 = 1'b0; wr0 = 5'd0; wr1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
    rr_ab = 10'd0; dbg_ab = 5'd0;
    w0_c = 1'b0; w1_c = 1'b0; wr0_c = 3'd0; wr1_c = 3'd0; wd0_c = 16'd0; wd1_c = 16'd0;
    rr_c = 9'd0; dbg_c_addr = 3'd0;
  endtask

  // Release reset at a falling edge and count sampled busy cycles (bounded).
  task automatic release_and_count(output int na, output int nc);
    na = 0; nc = 0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (busy_a) begin
        na++;
        total++;
        if (rd_a !== 64'd0 || rd_b !== 64'd0 || dbg_a !== 32'd0) begin
          bad++;
          $display("FAIL clear_reads_zero: rd_a=%h rd_b=%h dbg=%h want 0", rd_a, rd_b, dbg_a);
        end
      end
      if (busy_c) nc++;
      if (!busy_a && !busy_c) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int na, nc;
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rr_ab = {5'd5, 5'd2}; dbg_ab = 5'd2;
    #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    total++; if (rd_a !== 64'd0 || dbg_a !== 32'd0) begin bad++; $display("FAIL reset_reads: rd=%h dbg=%h want 0", rd_a, dbg_a); end
    release_and_count(na, nc);
    total++; if (na !== 32) begin bad++; $display("FAIL clear_len_32: got %0d want 32", na); end
    total++; if (nc !== 8) begin bad++; $display("FAIL clear_len_8: got %0d want 8", nc); end
    rr_c = {3'd1, 3'd0, 3'd2}; dbg_c_addr = 3'd2;
    #1;
    total++; if (rd_a[31:0] !== 32'h123) begin bad++; $display("FAIL preset_rd: got %h want 123", rd_a[31:0]); end
    total++; if (rd_a[63:32] !== 32'd0) begin bad++; $display("FAIL cleared_rd5: got %h want 0", rd_a[63:32]); end
    total++; if (dbg_a !== 32'h123) begin bad++; $display("FAIL preset_dbg: got %h want 123", dbg_a); end
    total++; if (rd_b !== {32'd0, 32'h123}) begin bad++; $display("FAIL preset_rd_b: got %h", rd_b); end
    total++; if (rd_c !== {16'd0, 16'd0, 16'h0123}) begin bad++; $display("FAIL preset_c: got %h want 000000000123", rd_c); end
    total++; if (dbg_c !== 16'h0123) begin bad++; $display("FAIL preset_dbg_c: got %h want 0123", dbg_c); end
    init_models();
  endtask

  task automatic test_bypass();
    @(negedge clk);
    w0 = 1'b1; wr0 = 5'd3; wd0 = 32'hDEAD_BEEF; rr_ab = {5'd0, 5'd3}; dbg_ab = 5'd3;
    #1;
    total++; if (rd_a[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_same: got %h want deadbeef", rd_a[31:0]); end
    total++; if (rd_b[31:0] !== 32'd0) begin bad++; $display("FAIL nobypass_same: got %h want 0", rd_b[31:0]); end
    total++; if (dbg_a !== 32'd0) begin bad++; $display("FAIL dbg_before_edge: got %h want 0", dbg_a); end
    @(posedge clk); commit_models();
    @(negedge clk); w0 = 1'b0;
    #1;
    total++; if (rd_b[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL nobypass_next: got %h want deadbeef", rd_b[31:0]); end
    total++; if (dbg_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dbg_after_edge: got %h want deadbeef", dbg_a); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    w0 = 1'b1; w1 = 1'b1; wr0 = 5'd7; wr1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22; rr_ab = {5'd7, 5'd7};
    #1;
    total++; if (rd_a[31:0] !== 32'h22) begin bad++; $display("FAIL bypass_prio: got %h want 22", rd_a[31:0]); end
    @(posedge clk); commit_models();
    @(negedge clk); w0 = 1'b0; w1 = 1'b0;
    #1;
    total++; if (rd_b[31:0] !== 32'h22) begin bad++; $display("FAIL same_addr_win: got %h want 22", rd_b[31:0]); end
    @(negedge clk);
    w0 = 1'b1; w1 = 1'b1; wr0 = 5'd8; wr1 = 5'd9; wd0 = 32'hAAAA_0008; wd1 = 32'h5555_0009; rr_ab = {5'd9, 5'd8};
    @(posedge clk); commit_models();
    @(negedge clk); w0 = 1'b0; w1 = 1'b0;
    #1;
    total++; if (rd_b !== {32'h5555_0009, 32'hAAAA_0008}) begin bad++; $display("FAIL diff_addr_both: got %h", rd_b); end
  endtask

  task automatic test_zero_reg();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      if (p == 0) begin w0 = 1'b1; wr0 = 5'd0; wd0 = 32'hFFFF_FFFF; end
      else begin w1 = 1'b1; wr1 = 5'd0; wd1 = 32'hFFFF_FFFF; end
      rr_ab = 10'd0; dbg_ab = 5'd0;
      #1;
      total++; if (rd_a !== 64'd0) begin bad++; $display("FAIL zero_bypass p%0d: got %h want 0", p, rd_a); end
      @(posedge clk); commit_models();
      @(negedge clk); w0 = 1'b0; w1 = 1'b0;
      #1;
      total++; if (rd_b !== 64'd0 || dbg_a !== 32'd0) begin bad++; $display("FAIL zero_stored p%0d: rd=%h dbg=%h want 0", p, rd_b, dbg_a); end
    end
  endtask

  task automatic test_param_c();
    @(negedge clk);
    w0_c = 1'b1; wr0_c = 3'd3; wd0_c = 16'hBEEF; w1_c = 1'b1; wr1_c = 3'd5; wd1_c = 16'h1234;
    @(posedge clk); commit_models();
    @(negedge clk); w0_c = 1'b0; w1_c = 1'b0; rr_c = {3'd2, 3'd5, 3'd3};
    #1;
    total++; if (rd_c !== {16'h0123, 16'h1234, 16'hBEEF}) begin bad++; $display("FAIL c_three_ports: got %h want 01231234beef", rd_c); end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      w0 = 1'($urandom); w1 = 1'($urandom);
      wr0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      rr_ab = {5'($urandom_range(0, 9)), 5'($urandom)}; dbg_ab = 5'($urandom_range(0, 9));
      w0_c = 1'($urandom); w1_c = 1'($urandom); wr0_c = 3'($urandom); wr1_c = 3'($urandom);
      wd0_c = 16'($urandom); wd1_c = 16'($urandom); rr_c = 9'($urandom); dbg_c_addr = 3'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_a[k*32 +: 32] !== exp_ab(rr_ab[k*5 +: 5], 1'b1)) begin
          bad++; $display("FAIL rand_a port%0d addr %0d: got %h want %h", k, rr_ab[k*5 +: 5], rd_a[k*32 +: 32], exp_ab(rr_ab[k*5 +: 5], 1'b1));
        end
        total++;
        if (rd_b[k*32 +: 32] !== exp_ab(rr_ab[k*5 +: 5], 1'b0)) begin
          bad++; $display("FAIL rand_b port%0d addr %0d: got %h want %h", k, rr_ab[k*5 +: 5], rd_b[k*32 +: 32], exp_ab(rr_ab[k*5 +: 5], 1'b0));
        end
      end
      total++;
      if (dbg_a !== ref_ab[dbg_ab]) begin bad++; $display("FAIL rand_dbg addr %0d: got %h want %h", dbg_ab, dbg_a, ref_ab[dbg_ab]); end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rd_c[k*16 +: 16] !== exp_c(rr_c[k*3 +: 3])) begin
          bad++; $display("FAIL rand_c port%0d: got %h want %h", k, rd_c[k*16 +: 16], exp_c(rr_c[k*3 +: 3]));
        end
      end
      total++;
      if (dbg_c !== ref_c[dbg_c_addr]) begin bad++; $display("FAIL rand_dbg_c: got %h want %h", dbg_c, ref_c[dbg_c_addr]); end
      @(posedge clk); commit_models();
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    int na, nc;
    @(negedge clk);
    w0 = 1'b1; wr0 = 5'd4; wd0 = 32'h55; rr_ab = {5'd0, 5'd4};
    @(posedge clk); commit_models();
    @(negedge clk); w0 = 1'b0;
    #1;
    total++; if (rd_b[31:0] !== 32'h55) begin bad++; $display("FAIL mid_pre_write: got %h want 55", rd_b[31:0]); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    w0 = 1'b1; wr0 = 5'd4; wd0 = 32'h99; rr_ab = {5'd4, 5'd4}; dbg_ab = 5'd4;
    release_and_count(na, nc);
    total++; if (na !== 32) begin bad++; $display("FAIL mid_clear_len: got %0d want 32", na); end
    total++; if (nc !== 8) begin bad++; $display("FAIL mid_clear_len_c: got %0d want 8", nc); end
    w0 = 1'b0;
    #1;
    total++; if (rd_b !== 64'd0 || dbg_a !== 32'd0) begin bad++; $display("FAIL mid_entry4: rd=%h dbg=%h want 0", rd_b, dbg_a); end
    init_models();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    init_models();
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_param_c();
    test_random(200);
    test_reset_mid();
    test_random(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
